addsub16_result_stage: RTL and testbench
========================================

# addsub16_result_stage

Registered result-capture stage directly downstream of the combinational 16-bit add/subtract unit (`adder_16bit_s`). It accepts the unit's SUM/C_out/O outputs under a valid/ready handshake and buffers them in a small FIFO. On signed overflow it can optionally saturate the result, and it keeps an overflow event counter and a sticky flag for software. This stage turns the combinational datapath into a pipelined, back-pressurable producer for the register-file or writeback logic.

## Interface
- `WIDTH`, 16: datapath width; must match the adder.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `SAT_EN`, 0: 1 = replace overflowed results with the saturated value.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `in_valid`  in  1  upstream result present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_sum`  in  WIDTH  adder SUM.
- `in_c_out`  in  1  adder C_out (raw; borrow-inverted when subtracting).
- `in_o`  in  1  adder signed-overflow flag O.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  WIDTH  head result, saturated if `SAT_EN` and overflow.
- `out_c`  out  1  head carry.
- `out_o`  out  1  head overflow (always the raw flag, even when saturated).
- `count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `ovf_cnt`  out  16  overflow events accepted; saturates at 0xFFFF.
- `ovf_sticky`  out  1  set by any accepted overflow.
- `clr`  in  1  clears `ovf_cnt` and `ovf_sticky`.

## Operation
- Push happens when `in_valid && in_ready`. Pop happens when `out_valid && out_ready`.
- Each entry is {o, c, data}, WIDTH+2 bits wide.
- The entry is built at push time. If `SAT_EN` and `in_o` are both set, data is 0x7FFF when `in_sum[15]`=1 (the true result is positive) and 0x8000 when `in_sum[15]`=0. Otherwise data is `in_sum` unchanged.
- FIFO behaviour:
  - `in_ready` = (count < DEPTH).
  - `out_valid` = (count != 0).
  - Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- When full, `in_ready` stays 0 even if a pop occurs that cycle. There is no ready-through path.
- Overflow counter, on each push with `in_o`=1:
  - `ovf_cnt` increments, holding at 0xFFFF.
  - `ovf_sticky` is set.
- `clr` together with a counted push in the same cycle: `ovf_cnt`=1 and `ovf_sticky`=1. Clear applies first, then the event is counted.
- `clr` alone: `ovf_cnt`=0 and `ovf_sticky`=0.
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `ovf_cnt`=0, `ovf_sticky`=0, pointers 0, and `out_data`/`out_c`/`out_o` = 0.
- Reset mid-operation flushes all entries; any in-flight handshake is discarded.
- Data outputs are a don't-care while `out_valid`=0, except directly after reset, when they are 0.

## Timing
- Latency is 1 cycle: a push at edge N makes `out_valid`=1 after edge N when the FIFO was empty. There is no combinational in-to-out path.
- Throughput is one result per cycle while neither side stalls.
- `in_ready` and `out_valid` are functions of registered count only.
- `out_data` is driven from the FIFO array read at the head pointer. The FIFO read is combinational from registered state.
- Upstream must hold `in_sum`/`in_c_out`/`in_o` stable while `in_valid`=1 and `in_ready`=0.
- Downstream sees the head entry stable until it is popped.

## Structure
- Package `addsub_pkg` holds:
  - `ADDSUB_W`=16
  - `ENTRY_W`=ADDSUB_W+2
  - `SAT_POS`=16'h7FFF
  - `SAT_NEG`=16'h8000
  - the entry typedef {o, c, data}
- One sub-module, `addsub_fifo`: a parameterised synchronous FIFO (width, depth) with push/pop/count.
- Saturation and the overflow counter live in the top level.

## Test plan
- Add 0x7FFF + 0x0001, `SAT_EN`=0 -> one cycle later `out_data`=0x8000, `out_c`=0, `out_o`=1, `ovf_cnt`=1, `ovf_sticky`=1.
- Subtract 0x8000 − 0x0001 (`in_sum`=0x7FFF, `in_o`=1), `SAT_EN`=1 -> `out_data`=0x8000, `out_o`=1. Also: 0x7FFF + 0x0001 -> `out_data`=0x7FFF.
- Back-pressure with `out_ready`=0:
  - push 0x0001..0x0004 -> `count`=4, `in_ready`=0;
  - hold 0x0005 for 3 cycles -> not accepted;
  - raise `out_ready` -> pops appear in order 0x0001..0x0005 with no loss or duplication.
- Streaming: `in_valid`=`out_ready`=1 for 100 cycles with random sums -> `count` stays at 1 and output equals input delayed by 1 cycle.
- `clr` in the same cycle as an overflowed push -> `ovf_cnt`=1. 65 536 overflowed pushes -> `ovf_cnt` holds at 0xFFFF.
- Assert `rst_n`=0 with 3 entries queued -> next cycle `count`=0, `out_valid`=0, `in_ready`=1, `ovf_cnt`=0.

Source files
------------

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared constants and the FIFO entry layout for the add/subtract result
// capture stage.
//   ADDSUB_W : datapath width of the adder feeding the stage
//   ENTRY_W  : width of one buffered entry {o, c, data}
//   SAT_POS  : saturated value when the true result overflowed positive
//   SAT_NEG  : saturated value when the true result overflowed negative
// ---------------------------------------------------------------------------
package addsub_pkg;

   localparam int ADDSUB_W = 16;
   localparam int ENTRY_W  = ADDSUB_W + 2;

   localparam logic [ADDSUB_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [ADDSUB_W-1:0] SAT_NEG = 16'h8000;

   typedef struct packed {
      logic                o;
      logic                c;
      logic [ADDSUB_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/addsub_fifo.sv
// ---------------------------------------------------------------------------
// addsub_fifo
// Parameterised synchronous FIFO. Storage is a plain array (no reset) so it
// can map to distributed/block RAM; the head is read combinationally from
// registered pointer state.
//   clk     : clock
//   rst_n   : synchronous active-low reset (pointers and count only)
//   i_push  : write wdata (ignored when full)
//   i_pop   : drop the head entry (ignored when empty)
//   i_wdata : entry to write
//   o_rdata : entry at the head pointer
//   o_count : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module addsub_fifo
   import addsub_pkg::*;
#(
   parameter int W     = ENTRY_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign w_do_push = i_push && (r_count != CW'(DEPTH));
   assign w_do_pop  = i_pop  && (r_count != '0);

   // DEPTH is a power of two, so pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/addsub16_result_stage.sv
// ---------------------------------------------------------------------------
// addsub16_result_stage
// Registered capture stage behind the combinational 16-bit add/subtract
// unit. Buffers {O, C_out, SUM} in a FIFO under valid/ready, optionally
// saturates overflowed results, and tracks overflow events for software.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_sum/in_c_out/in_o: adder SUM, raw carry, signed overflow
//   out_valid/out_ready : downstream handshake
//   out_data/out_c/out_o: head entry (out_o is always the raw flag)
//   count               : FIFO occupancy
//   ovf_cnt/ovf_sticky  : accepted-overflow counter (saturating) and flag
//   clr                 : clears ovf_cnt and ovf_sticky
// ---------------------------------------------------------------------------
module addsub16_result_stage
   import addsub_pkg::*;
#(
   parameter int WIDTH  = ADDSUB_W,
   parameter int DEPTH  = 4,
   parameter bit SAT_EN = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_sum,
   input  logic                     in_c_out,
   input  logic                     in_o,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_c,
   output logic                     out_o,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              ovf_cnt,
   output logic                     ovf_sticky,
   input  logic                     clr
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          w_push;
   logic          w_pop;
   entry_t        w_wr_entry;
   entry_t        w_rd_entry;
   logic [CW-1:0] w_count;
   logic [15:0]   r_ovf_cnt;
   logic          r_ovf_sticky;

   assign in_ready  = (w_count < CW'(DEPTH));
   assign out_valid = (w_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // On overflow the sign bit of SUM is wrong, so SUM[15]=1 means the true
   // result was positive.
   always_comb begin
      w_wr_entry   = '0;
      w_wr_entry.o = in_o;
      w_wr_entry.c = in_c_out;
      if (SAT_EN && in_o)
         w_wr_entry.data = in_sum[WIDTH-1] ? SAT_POS : SAT_NEG;
      else
         w_wr_entry.data = in_sum;
   end

   addsub_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wr_entry),
      .o_rdata (w_rd_entry),
      .o_count (w_count)
   );

   // Clear takes effect first, so clear plus a counted push leaves 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf_cnt    <= '0;
         r_ovf_sticky <= 1'b0;
      end else if (w_push && in_o) begin
         r_ovf_sticky <= 1'b1;
         if (clr)
            r_ovf_cnt <= 16'd1;
         else if (r_ovf_cnt != 16'hFFFF)
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end else if (clr) begin
         r_ovf_cnt    <= '0;
         r_ovf_sticky <= 1'b0;
      end
   end

   // Storage is not reset; zero the head while empty so outputs read 0
   // after reset.
   assign out_data   = out_valid ? w_rd_entry.data : '0;
   assign out_c      = out_valid ? w_rd_entry.c    : 1'b0;
   assign out_o      = out_valid ? w_rd_entry.o    : 1'b0;
   assign count      = w_count;
   assign ovf_cnt    = r_ovf_cnt;
   assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_addsub16_result_stage.sv
module tb_addsub16_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_sum;
   logic        in_c_out;
   logic        in_o;
   logic        out_ready;
   logic        clr;

   // dut0: SAT_EN=0, dut1: SAT_EN=1, same stimulus
   logic        in_ready0, out_valid0, out_c0, out_o0, ovf_sticky0;
   logic [15:0] out_data0, ovf_cnt0;
   logic [2:0]  count0;
   logic        in_ready1, out_valid1, out_c1, out_o1, ovf_sticky1;
   logic [15:0] out_data1, ovf_cnt1;
   logic [2:0]  count1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addsub16_result_stage #(.WIDTH(16), .DEPTH(4), .SAT_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_sum(in_sum), .in_c_out(in_c_out), .in_o(in_o),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_c(out_c0), .out_o(out_o0), .count(count0), .ovf_cnt(ovf_cnt0),
      .ovf_sticky(ovf_sticky0), .clr(clr)
   );

   addsub16_result_stage #(.WIDTH(16), .DEPTH(4), .SAT_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_sum(in_sum), .in_c_out(in_c_out), .in_o(in_o),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_c(out_c1), .out_o(out_o1), .count(count1), .ovf_cnt(ovf_cnt1),
      .ovf_sticky(ovf_sticky1), .clr(clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge; outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] popped [$];
   logic [15:0] stream_vals [100];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_c_out = 1'b0;
      in_o = 1'b0; out_ready = 1'b0; clr = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // reset state
      check("rst_count", 32'(count0), 0);
      check("rst_out_valid", 32'(out_valid0), 0);
      check("rst_in_ready", 32'(in_ready0), 1);
      check("rst_ovf_cnt", 32'(ovf_cnt0), 0);
      check("rst_sticky", 32'(ovf_sticky0), 0);
      check("rst_out_data", 32'(out_data0), 0);
      check("rst_out_c", 32'(out_c0), 0);
      check("rst_out_o", 32'(out_o0), 0);
      $display("txn reset: count=%0d in_ready=%0d", count0, in_ready0);

      // 0x7FFF + 0x0001: SUM=0x8000, C=0, O=1
      in_valid = 1'b1; in_sum = 16'h8000; in_c_out = 1'b0; in_o = 1'b1;
      tick();
      in_valid = 1'b0; in_o = 1'b0;
      check("add_ovf_valid", 32'(out_valid0), 1);
      check("add_ovf_data_nosat", 32'(out_data0), 32'h8000);
      check("add_ovf_c", 32'(out_c0), 0);
      check("add_ovf_o", 32'(out_o0), 1);
      check("add_ovf_cnt", 32'(ovf_cnt0), 1);
      check("add_ovf_sticky", 32'(ovf_sticky0), 1);
      check("add_ovf_data_sat", 32'(out_data1), 32'h7FFF);
      check("add_ovf_o_sat", 32'(out_o1), 1);
      $display("txn add_ovf: data0=%h data1=%h ovf_cnt=%0d", out_data0, out_data1, ovf_cnt0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pop1_count", 32'(count0), 0);

      // 0x8000 - 0x0001: SUM=0x7FFF, raw C=1, O=1
      in_valid = 1'b1; in_sum = 16'h7FFF; in_c_out = 1'b1; in_o = 1'b1;
      tick();
      in_valid = 1'b0; in_o = 1'b0; in_c_out = 1'b0;
      check("sub_ovf_data_sat", 32'(out_data1), 32'h8000);
      check("sub_ovf_o_sat", 32'(out_o1), 1);
      check("sub_ovf_c_sat", 32'(out_c1), 1);
      check("sub_ovf_data_nosat", 32'(out_data0), 32'h7FFF);
      check("sub_ovf_cnt", 32'(ovf_cnt0), 2);
      $display("txn sub_ovf: data0=%h data1=%h ovf_cnt=%0d", out_data0, out_data1, ovf_cnt0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // clr alone
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_cnt", 32'(ovf_cnt0), 0);
      check("clr_sticky", 32'(ovf_sticky0), 0);
      $display("txn clr: ovf_cnt=%0d sticky=%0d", ovf_cnt0, ovf_sticky0);

      // clr with an overflowed push
      clr = 1'b1; in_valid = 1'b1; in_sum = 16'h8000; in_o = 1'b1;
      tick();
      clr = 1'b0; in_o = 1'b0; in_sum = 16'h1234;
      check("clr_push_cnt", 32'(ovf_cnt0), 1);
      check("clr_push_sticky", 32'(ovf_sticky0), 1);
      $display("txn clr+ovf: ovf_cnt=%0d", ovf_cnt0);
      // non-overflow push leaves counter alone
      tick();
      in_valid = 1'b0;
      check("noovf_push_cnt", 32'(ovf_cnt0), 1);
      check("noovf_push_count", 32'(count0), 2);
      out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
      check("drain_count", 32'(count0), 0);

      // back-pressure: fill with 1..4
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_sum = 16'(i);
         tick();
      end
      check("full_count", 32'(count0), 4);
      check("full_in_ready", 32'(in_ready0), 0);
      in_sum = 16'h0005;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_count", 32'(count0), 4);
      end
      check("hold_head", 32'(out_data0), 1);
      $display("txn backpressure: count=%0d head=%h", count0, out_data0);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         logic will_push;
         will_push = in_valid && in_ready0;
         if (out_valid0) popped.push_back(out_data0);
         tick();
         if (will_push) in_valid = 1'b0;
         if (!in_valid && count0 == 0) break;
      end
      out_ready = 1'b0;
      check("bp_pop_total", 32'(popped.size()), 5);
      for (int i = 0; i < popped.size() && i < 5; i++) begin
         check("bp_pop_order", 32'(popped[i]), 32'(i + 1));
         $display("txn pop %0d: data=%h", i, popped[i]);
      end
      check("bp_final_count", 32'(count0), 0);

      // streaming: one per cycle, head tracks the previous push
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         stream_vals[i] = 16'($urandom);
         in_sum = stream_vals[i];
         tick();
         check("stream_count", 32'(count0), 1);
         check("stream_data", 32'(out_data0), 32'(stream_vals[i]));
      end
      $display("txn stream: 100 results, last=%h", out_data0);
      in_valid = 1'b0; tick();
      check("stream_drain", 32'(count0), 0);

      // overflow counter saturation
      clr = 1'b1; tick(); clr = 1'b0;
      in_valid = 1'b1; in_o = 1'b1; in_sum = 16'h8000;
      for (int i = 0; i < 65534; i++) tick();
      check("ovf_cnt_fffe", 32'(ovf_cnt0), 32'hFFFE);
      tick();
      check("ovf_cnt_ffff", 32'(ovf_cnt0), 32'hFFFF);
      tick(); tick();
      check("ovf_cnt_hold", 32'(ovf_cnt0), 32'hFFFF);
      $display("txn ovf_sat: ovf_cnt=%h", ovf_cnt0);
      in_valid = 1'b0; in_o = 1'b0; tick();

      // reset with 3 entries queued
      out_ready = 1'b0; in_valid = 1'b1; in_o = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("pre_rst_count", 32'(count0), 3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; in_valid = 1'b0; in_o = 1'b0;
      check("midrst_count", 32'(count0), 0);
      check("midrst_out_valid", 32'(out_valid0), 0);
      check("midrst_in_ready", 32'(in_ready0), 1);
      check("midrst_ovf_cnt", 32'(ovf_cnt0), 0);
      check("midrst_sticky", 32'(ovf_sticky0), 0);
      check("midrst_out_data", 32'(out_data0), 0);
      $display("txn midreset: count=%0d ovf_cnt=%0d", count0, ovf_cnt0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
